// File: rtl/run_one_readout_pkg.sv
// Shared constants and state encoding for the run/ones statistics readout block.
package run_one_pkg;
    localparam int LANES  = 32;
    localparam int CW     = 64;
    localparam int NWORDS = 2 * LANES + 1;
    localparam int IDXW   = 7;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACCUM,
        STREAM,
        DONE
    } ro_state_t;
endpackage

// File: rtl/run_one_readout_if.sv
// Valid/ready word stream from the readout block to the host-side FIFO.
interface run_one_readout_if;
    import run_one_pkg::*;

    logic [CW-1:0]   m_data;
    logic [IDXW-1:0] m_index;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;

    modport master (output m_data, m_index, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_index, m_valid, m_last, output m_ready);
endinterface

// File: rtl/run_one_readout.sv
// Runs one accumulation window of the run/ones counter, snapshots its 65 words
// and streams them out; owns the counter's enable.
module run_one_readout
    import run_one_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CW-1:0]     len,
    output logic              acc_enable,
    input  logic [CW-1:0]     total_in,
    input  logic [CW-1:0]     runs_in [LANES],
    input  logic [CW-1:0]     ones_in [LANES],
    run_one_readout_if.master m,
    output logic              busy,
    output logic              done
);
    ro_state_t       state_q;
    logic [CW-1:0]   len_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [CW-1:0]   data_q;
    logic [CW-1:0]   word_d;
    logic            acc_en_q;
    logic            valid_q;
    logic            last_q;
    logic            busy_q;
    logic            done_q;
    logic            capture;
    logic [CW-1:0]   snap_q [NWORDS];

    assign capture = (state_q == ACCUM) && (total_in == len_q);
    assign ptr_d   = ptr_q + IDXW'(1);
    // Word 0 goes straight from total_in at capture, so the mux only ever serves ptr_d >= 1.
    assign word_d  = snap_q[ptr_d];

    // NOTE: the snapshot array has no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            snap_q[0] <= total_in;
            for (int i = 0; i < LANES; i++) begin
                snap_q[1 + i]         <= runs_in[i];
                snap_q[1 + LANES + i] <= ones_in[i];
            end
        end
    end

    // NOTE: every register below is assigned with <= so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            ptr_q    <= '0;
            data_q   <= '0;
            acc_en_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q   <= len;
                        busy_q  <= 1'b1;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    acc_en_q <= 1'b1;
                    state_q  <= ACCUM;
                end
                ACCUM: begin
                    if (capture) begin
                        acc_en_q <= 1'b0;
                        ptr_q    <= '0;
                        data_q   <= total_in;
                        valid_q  <= 1'b1;
                        last_q   <= 1'b0;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (valid_q && m.m_ready) begin
                        if (ptr_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            ptr_q  <= ptr_d;
                            data_q <= word_d;
                            last_q <= (ptr_d == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign acc_enable = acc_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign m.m_data   = data_q;
    assign m.m_index  = ptr_q;
    assign m.m_valid  = valid_q;
    assign m.m_last   = last_q;
endmodule

// File: tb/tb_run_one_readout.sv
// Bench for run_one_readout: a behavioural run/ones counter feeds the DUT and
// streamed words are compared with values computed from the recorded samples.
module tb_run_one_readout;
    import run_one_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [CW-1:0]   len = '0;
    logic            acc_enable;
    logic            busy;
    logic            done;
    logic [CW-1:0]   total_in;
    logic [CW-1:0]   runs_in [LANES];
    logic [CW-1:0]   ones_in [LANES];
    logic [LANES-1:0] prev_bit;
    logic [LANES-1:0] rand_num = '0;
    int              mode = 0;

    logic [LANES-1:0] samples [$];
    logic [CW-1:0]    got_data [$];
    logic [IDXW-1:0]  got_idx [$];

    int n_checks = 0;
    int n_errors = 0;

    run_one_readout_if sif ();

    run_one_readout dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .acc_enable (acc_enable),
        .total_in   (total_in),
        .runs_in    (runs_in),
        .ones_in    (ones_in),
        .m          (sif),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Sample source: 0 = constant pattern, 1 = lane 0 alternating, 2 = random.
    always @(negedge clk) begin
        case (mode)
            0:       rand_num <= 32'hFFFF0000;
            1:       rand_num <= {31'b0, ~rand_num[0]};
            default: rand_num <= $urandom;
        endcase
    end

    // Statistics counter stand-in: counts while enabled, clears while disabled.
    always @(posedge clk) begin
        if (acc_enable === 1'b1) begin
            total_in <= total_in + CW'(1);
            for (int l = 0; l < LANES; l++) begin
                ones_in[l] <= ones_in[l] + CW'(rand_num[l]);
                runs_in[l] <= runs_in[l] +
                    (((total_in == '0) || (rand_num[l] != prev_bit[l])) ? CW'(1) : CW'(0));
            end
            prev_bit <= rand_num;
            samples.push_back(rand_num);
        end else begin
            total_in <= '0;
            for (int l = 0; l < LANES; l++) begin
                runs_in[l] <= '0;
                ones_in[l] <= '0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected word from the first n recorded samples: runs = number of maximal
    // runs of equal bits in the lane, ones = population count of the lane.
    function automatic logic [CW-1:0] exp_word(int idx, int n);
        int lane;
        int cnt;
        if (n > samples.size()) n = samples.size();
        if (idx == 0) return CW'(n);
        if (idx <= LANES) begin
            lane = idx - 1;
            cnt = (n > 0) ? 1 : 0;
            for (int i = 1; i < n; i++)
                if (samples[i][lane] != samples[i-1][lane]) cnt++;
        end else begin
            lane = idx - 1 - LANES;
            cnt = 0;
            for (int i = 0; i < n; i++)
                if (samples[i][lane]) cnt++;
        end
        return CW'(cnt);
    endfunction

    task automatic run_window(input logic [CW-1:0] wlen, input int ready_pct, input bit poke);
        int cyc;
        int first_valid;
        int done_cyc;
        bit stalled;
        logic [CW-1:0]   hold_d;
        logic [IDXW-1:0] hold_i;
        samples.delete();
        got_data.delete();
        got_idx.delete();
        @(negedge clk);
        sif.m_ready = 1'b0;
        start = 1'b1;
        len = wlen;
        @(negedge clk);
        start = 1'b0;
        len = {$urandom, $urandom};
        check("busy_rise", busy, 1);
        check("acc_en_early", acc_enable, 0);
        @(negedge clk);
        check("acc_en_rise", acc_enable, 1);
        cyc = 2;
        first_valid = -1;
        done_cyc = -1;
        stalled = 1'b0;
        hold_d = '0;
        hold_i = '0;
        forever begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= 4000) break;
            start = poke && (cyc == 5);
            if (start) len = 3;
            if (sif.m_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check("stall_valid", sif.m_valid, 1);
                check("stall_data", sif.m_data, hold_d);
                check("stall_index", sif.m_index, hold_i);
            end
            sif.m_ready = ($urandom_range(99) < ready_pct);
            stalled = sif.m_valid && !sif.m_ready;
            hold_d = sif.m_data;
            hold_i = sif.m_index;
            if (sif.m_valid && sif.m_ready) begin
                check($sformatf("last%0d", got_idx.size()), sif.m_last,
                      got_idx.size() == NWORDS - 1);
                got_data.push_back(sif.m_data);
                got_idx.push_back(sif.m_index);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("first_valid", 64'(first_valid), wlen + 64'd3);
        check("n_words", 64'(got_data.size()), 64'(NWORDS));
        if (ready_pct >= 100) check("stream_time", 64'(done_cyc - first_valid), 64'(NWORDS));
        check("n_samples", 64'(samples.size() >= int'(wlen)), 1);
        for (int i = 0; i < got_data.size(); i++) begin
            check($sformatf("idx%0d", i), got_idx[i], 64'(i));
            check($sformatf("word%0d", i), got_data[i], exp_word(i, int'(wlen)));
        end
        sif.m_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_fall", busy, 0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int n_done;
        int n_valid;
        n_done = 0;
        n_valid = 0;
        repeat (cycles) begin
            if (done) n_done++;
            if (sif.m_valid) n_valid++;
            @(negedge clk);
        end
        check({tag, "_no_done"}, 64'(n_done), 0);
        check({tag, "_no_valid"}, 64'(n_valid), 0);
    endtask

    task automatic check_after_reset(input string tag);
        check({tag, "_acc_en"}, acc_enable, 0);
        check({tag, "_valid"}, sif.m_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int waited;
        sif.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc_en", acc_enable, 0);
        check("rst_valid", sif.m_valid, 0);
        check("rst_last", sif.m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", sif.m_data, 0);
        check("rst_index", sif.m_index, 0);
        rst = 1'b0;

        // Constant pattern with the counter integrated.
        mode = 0;
        run_window(10, 100, 1'b0);
        if (got_data.size() == NWORDS) begin
            check("t1_total", got_data[0], 10);
            for (int l = 0; l < LANES; l++) begin
                check($sformatf("t1_runs%0d", l), got_data[1 + l], 1);
                check($sformatf("t1_ones%0d", l), got_data[1 + LANES + l], (l >= 16) ? 10 : 0);
            end
        end

        // Alternating lane 0.
        mode = 1;
        run_window(8, 100, 1'b0);
        if (got_data.size() == NWORDS) begin
            check("alt_runs0", got_data[1], 8);
            check("alt_ones0", got_data[1 + LANES], 4);
        end

        // Random data with backpressure.
        mode = 2;
        for (int w = 0; w < 3; w++) run_window(64'($urandom_range(40, 1)), 30, 1'b0);

        // len == 0 is ignored.
        @(negedge clk);
        start = 1'b1;
        len = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            check("len0_acc_en", acc_enable, 0);
            check("len0_busy", busy, 0);
            @(negedge clk);
        end

        // start while busy is ignored.
        run_window(12, 60, 1'b1);

        // Reset in the middle of ACCUM.
        @(negedge clk);
        start = 1'b1;
        len = 20;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_acc_en", acc_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_after_reset("rst_accum");
        watch_quiet("rst_accum", 30);

        // Reset at word 20 of STREAM.
        @(negedge clk);
        start = 1'b1;
        len = 6;
        @(negedge clk);
        start = 1'b0;
        sif.m_ready = 1'b1;
        waited = 0;
        while (!(sif.m_valid && sif.m_index == 20) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("reach_word20", 64'(sif.m_valid && sif.m_index == 20), 1);
        rst = 1'b1;
        sif.m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_after_reset("rst_stream");
        watch_quiet("rst_stream", 80);

        run_window(5, 100, 1'b0);
        if (got_data.size() > 0) check("post_rst_word0", got_data[0], 5);

        // Shortest window.
        run_window(1, 100, 1'b0);
        if (got_data.size() > 0) check("len1_word0", got_data[0], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/run_one_readout.md
# run_one_readout

Controls one accumulation window of the per-lane run/ones statistics counter and reads back its results. On `start`, it holds the counter's enable high for exactly `len` samples, then snapshots all 65 counter words. It streams them to the host-side FIFO as 64-bit words over a valid/ready interface. This is the read side of the statistics path: the counter only writes while enabled and clears when disabled, and this block owns that enable.

## Interface
Parameters:
- `LANES`, 32: bit lanes in the statistics counter.
- `CW`, 64: counter and word width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to run a window; honoured only in IDLE.
- `len`  in  CW  number of samples in the window; sampled with `start`.
- `acc_enable`  out  1  drives the counter's enable; low clears the counter.
- `total_in`  in  CW  counter's sample total.
- `runs_in[LANES]`  in  CW each  per-lane transition counts.
- `ones_in[LANES]`  in  CW each  per-lane ones counts.
- `m_data`  out  CW  stream word.
- `m_index`  out  7  word index, 0..2*LANES.
- `m_valid`  out  1  word valid.
- `m_ready`  in  1  sink accepts.
- `m_last`  out  1  high with index 2*LANES.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE: `start` && `len`≠0 → ARM; latch `len` into `len_q`.
  - `start` with `len`==0 is ignored; the block stays in IDLE.
  - ARM: `acc_enable`<=1 → ACCUM.
  - ACCUM:
    - When `total_in`==`len_q`, capture `total_in`, `runs_in[]` and `ones_in[]` into the snapshot registers.
    - Same cycle: `acc_enable`<=0, word pointer <=0 → STREAM.
  - STREAM: present snapshot word[pointer].
    - On `m_valid`&&`m_ready`, pointer+1.
    - Handshake at pointer 2*LANES → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Word order:
  - Index 0: total.
  - Indices 1..LANES: `runs_in[0..LANES-1]`.
  - Indices LANES+1..2*LANES: `ones_in[0..LANES-1]`.
- Snapshot is taken from the registers only. After `acc_enable` falls, the counter clears; streamed values are unaffected.
- `start` while `busy` is ignored; no queueing.
- Comparison is full-width unsigned equality. `total_in` is never compared against a partial width.

## Timing
- Reset values:
  - `acc_enable`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0.
  - `m_data`=0, `m_index`=0, state=IDLE, snapshot registers are don't-care.
- `start` at cycle t:
  - `busy`=1 from t+1.
  - `acc_enable`=1 from t+2.
  - The counter sees enable at edges t+2 .. t+2+`len`.
  - `total_in`==`len` in cycle t+2+`len`; capture happens at that edge.
- The counter takes one extra sample at the capture edge. This is harmless because it is cleared afterwards.
- `m_valid` rises the cycle after capture. The word is held stable with `m_valid` high until accepted (AXI-stream rules). `m_valid` never drops without a handshake.
- Back-to-back transfers: one word per cycle while `m_ready`=1. Minimum stream time is 2*LANES+1 cycles.
- `done` is asserted in the cycle after the final handshake. `busy` falls in the cycle after `done`.
- `rst` mid-window or mid-stream:
  - Next cycle: IDLE, `acc_enable`=0 (which clears the counter), `m_valid`=0.
  - Partial streams are abandoned; no `done`.

## Structure
- Package `run_one_pkg`:
  - `LANES`, `CW`.
  - `NWORDS`=2*LANES+1.
  - `IDXW`=7.
  - State enum `ro_state_t` {IDLE, ARM, ACCUM, STREAM, DONE}.
- Single module, no sub-module. The output word mux from the snapshot array is combinational on the pointer, then registered into `m_data`.

## Test plan
- Integrated with the counter block:
  - Stimulus: `rand_num[0]`=32'hFFFF0000 constant, `len`=10.
  - Required: word0=10; runs lanes 0..31 =1; ones lanes 0..15 =0; ones lanes 16..31 =10; `m_last` on index 64; one `done` pulse.
- Alternating pattern:
  - Stimulus: lane 0 alternating 0,1,0,1…, `len`=8.
  - Required: runs[0]=8, ones[0]=4.
- Backpressure:
  - Stimulus: `m_ready` random at 30%.
  - Required: all 65 words in order; data stable while stalled; no duplicates or drops.
- `len`=0 and `start` while busy:
  - Required: both ignored; `acc_enable` stays 0 for the `len`=0 case.
  - The ongoing window completes unchanged.
- Reset at mid-ACCUM and at word 20 of STREAM:
  - Required: IDLE next cycle, `acc_enable`=0, `m_valid`=0, no `done`.
  - A new `start` with `len`=5 then yields word0=5.
- `len`=1:
  - Required: snapshot total=1; capture occurs 3 cycles after `start`.
